sync_debounce: RTL and testbench
================================

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: number of consecutive synchronized samples at a new level before `out` changes; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 5: stability counter width; SHALL satisfy 2**CNT_W > STABLE_CYCLES.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in  input  1  raw asynchronous level, e.g. a push-button or external pin.
REQ-006 out  output  1  debounced, synchronized level; drives the downstream edge-detector stage.
REQ-007 busy  output  1  high while a candidate transition is being qualified (WAIT_HIGH or WAIT_LOW).
REQ-008 glitch_cnt  output  8  count of rejected transitions; present only when DEBOUNCE_GLITCH_CNT_EN is defined.

Function
REQ-009 Two-flop synchronizer: s1 <= in, s2 <= s1 every cycle; the FSM SHALL use s2 only and never `in` directly.
REQ-010 FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW; `out` = 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH, registered.
REQ-011 LOW: s2=1 -> WAIT_HIGH, cnt <= 1; else stay, cnt <= 0.
REQ-012 WAIT_HIGH: s2=1 and cnt = STABLE_CYCLES-1 -> HIGH, cnt <= 0; s2=1 otherwise -> cnt <= cnt+1; s2=0 -> LOW, cnt <= 0, glitch event.
REQ-013 HIGH / WAIT_LOW SHALL mirror REQ-011/012 with the levels inverted (HIGH -> WAIT_LOW on s2=0; WAIT_LOW -> LOW after STABLE_CYCLES consecutive s2=0 samples; s2=1 in WAIT_LOW -> HIGH, glitch event).
REQ-014 Latency: when `in` changes and is held, `out` SHALL change on the (STABLE_CYCLES+1)th rising edge after the edge at which s1 first samples the new level.
REQ-015 A stable run shorter than STABLE_CYCLES samples SHALL leave `out` unchanged.
REQ-016 A transition that is aborted SHALL restart qualification from cnt = 1 on the next opposite sample; no partial credit is kept.
REQ-017 `out` SHALL be glitch-free: it changes at most once per qualified transition and never toggles within one cycle.
REQ-018 busy = 1 exactly in WAIT_HIGH and WAIT_LOW, registered with the state.
REQ-019 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While rst = 1 at a clock edge: s1, s2, cnt, out, busy <= 0, state <= LOW, glitch_cnt <= 0.
REQ-021 Reset asserted mid-qualification SHALL abandon the qualification with no change to `out` other than forcing 0; reset has priority over every transition.
REQ-022 After rst deasserts with in = 1 held, `out` SHALL rise per REQ-014, counting from the first post-reset edge.

Configuration
REQ-023 Macro DEBOUNCE_GLITCH_CNT_EN: when defined, port glitch_cnt and an 8-bit counter exist and increment by 1 on each glitch event (REQ-012/013), saturating at 255; when undefined, the port and counter are absent and all other behaviour is identical.

Verification (STABLE_CYCLES = 4, CNT_W = 3)
REQ-024 Reset, then `in` 0 -> 1 held: out = 0 for 4 edges after s1 samples 1, out = 1 on the 5th; busy high on edges 2-4.
REQ-025 `in` high for 3 cycles then low: out stays 0; glitch_cnt 0 -> 1 (macro on).
REQ-026 From out = 1, `in` low for 2 cycles, high 1 cycle, low held: out falls 5 edges after the final low is first sampled; glitch_cnt +1.
REQ-027 rst pulsed while in WAIT_HIGH with cnt = 2: out = 0, busy = 0, glitch_cnt = 0 next cycle; with in still high, out rises 5 edges after reset deasserts.
REQ-028 300 rejected 1-cycle pulses with the macro on: glitch_cnt saturates at 255, out stays 0; rebuild without the macro: port absent, out trace identical.

Source files
------------

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus a four-state debounce FSM qualifying each level change over STABLE_CYCLES samples.
// Optional rejected-transition counter (glitch_cnt) is built only when DEBOUNCE_GLITCH_CNT_EN is defined.
module sync_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       out,
  output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;
  logic             busy_q;
  logic             busy_d;

  // Synchronizer: the FSM only ever looks at s2_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  // An aborted qualification drops straight back with cnt cleared, so no partial credit survives.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    out_d  = (state_d == HIGH) || (state_d == WAIT_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign out  = out_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q;
  logic       glitch_ev;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign glitch_ev = ((state_q == WAIT_HIGH) && !s2_q) ||
                     ((state_q == WAIT_LOW)  &&  s2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= 8'd0;
    end else if (glitch_ev) begin
      glitch_q <= sat_inc8(glitch_q);
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce (STABLE_CYCLES=4): directed scenarios plus randomized runs against a run-length reference model.
module tb_sync_debounce;
  localparam int SC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;
  logic dbusy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gcnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: s1/s2 delay line, debounced level, length of current opposite run, glitch tally.
  logic m_s1, m_s2, m_out;
  int   m_run;
  int   m_glitch;

  always #5 clk = ~clk;

  sync_debounce #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout),
    .busy(dbusy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(gcnt)
`endif
  );

  task automatic step(input logic v, input logic r);
    logic old_s2;
    din = v;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_run = 0; m_glitch = 0;
    end else begin
      old_s2 = m_s2;
      m_s2   = m_s1;
      m_s1   = v;
      if (old_s2 != m_out) begin
        m_run++;
        if (m_run == SC) begin
          m_out = ~m_out;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (dout !== 1'b0) begin failures++; $display("FAIL reset_out: got=%0b exp=0", dout); end
    checks++;
    if (dbusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%0b exp=0", dbusy); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gcnt !== 8'd0) begin failures++; $display("FAIL reset_glitch: got=%0d exp=0", gcnt); end
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
  endtask

  // s1 samples the new level at edge 0; out must rise on edge SC+1, busy high on edges 2..SC.
  task automatic test_rise_latency();
    logic eo, eb;
    for (int k = 0; k <= SC + 2; k++) begin
      step(1'b1, 1'b0);
      eo = (k >= SC + 1);
      eb = (k >= 2) && (k <= SC);
      checks++;
      if (dout !== eo || m_out !== eo) begin
        failures++; $display("FAIL rise_out edge%0d: got=%0b model=%0b exp=%0b", k, dout, m_out, eo);
      end
      checks++;
      if (dbusy !== eb) begin failures++; $display("FAIL rise_busy edge%0d: got=%0b exp=%0b", k, dbusy, eb); end
    end
  endtask

  task automatic test_short_pulse();
    int g0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    g0 = m_glitch;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (dout !== 1'b0) begin failures++; $display("FAIL short_out cyc%0d: got=%0b exp=0", i, dout); end
    end
    checks++;
    if (dbusy !== 1'b0) begin failures++; $display("FAIL short_busy: got=%0b exp=0", dbusy); end
    checks++;
    if (m_glitch != g0 + 1) begin failures++; $display("FAIL short_model_glitch: got=%0d exp=%0d", m_glitch, g0 + 1); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gcnt !== 8'd1) begin failures++; $display("FAIL short_glitch: got=%0d exp=1", gcnt); end
`endif
  endtask

  task automatic test_fall_glitch();
    logic eo;
    for (int i = 0; i < SC + 4; i++) step(1'b1, 1'b0);
    checks++;
    if (dout !== 1'b1) begin failures++; $display("FAIL fall_pre_out: got=%0b exp=1", dout); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 0; k <= SC + 2; k++) begin
      step(1'b0, 1'b0);
      eo = (k < SC + 1);
      checks++;
      if (dout !== eo) begin failures++; $display("FAIL fall_out edge%0d: got=%0b exp=%0b", k, dout, eo); end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gcnt !== 8'd2) begin failures++; $display("FAIL fall_glitch: got=%0d exp=2", gcnt); end
`endif
  endtask

  // Reset lands while WAIT_HIGH holds cnt=2, then in stays high through recovery.
  task automatic test_reset_mid();
    logic eo;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    checks++;
    if (dbusy !== 1'b1) begin failures++; $display("FAIL mid_pre_busy: got=%0b exp=1", dbusy); end
    step(1'b1, 1'b1);
    checks++;
    if (dout !== 1'b0 || dbusy !== 1'b0) begin
      failures++; $display("FAIL mid_reset: out=%0b busy=%0b exp=0/0", dout, dbusy);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gcnt !== 8'd0) begin failures++; $display("FAIL mid_glitch: got=%0d exp=0", gcnt); end
`endif
    for (int k = 0; k <= SC + 2; k++) begin
      step(1'b1, 1'b0);
      eo = (k >= SC + 1);
      checks++;
      if (dout !== eo) begin failures++; $display("FAIL mid_recover edge%0d: got=%0b exp=%0b", k, dout, eo); end
    end
  endtask

  task automatic test_random();
    logic lvl;
    logic r;
    int   len;
    lvl = 1'b0;
    for (int n = 0; n < 80; n++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 2 * SC);
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, 59) == 0);
        step(lvl, r);
        checks++;
        if (dout !== m_out) begin failures++; $display("FAIL rand_out run%0d: got=%0b exp=%0b", n, dout, m_out); end
        checks++;
        if (dbusy !== (m_run > 0)) begin
          failures++; $display("FAIL rand_busy run%0d: got=%0b exp=%0b", n, dbusy, (m_run > 0));
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (gcnt !== 8'(m_glitch)) begin
          failures++; $display("FAIL rand_glitch run%0d: got=%0d exp=%0d", n, gcnt, m_glitch);
        end
`endif
      end
    end
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int p = 0; p < 300; p++) begin
      step(1'b1, 1'b0);
      if (dout !== 1'b0) bad++;
      step(1'b0, 1'b0);
      if (dout !== 1'b0) bad++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL sat_out: high_samples=%0d exp=0", bad); end
    checks++;
    if (m_glitch != 255) begin failures++; $display("FAIL sat_model: got=%0d exp=255", m_glitch); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gcnt !== 8'd255) begin failures++; $display("FAIL sat_glitch: got=%0d exp=255", gcnt); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_run = 0; m_glitch = 0;
    test_reset();
    test_rise_latency();
    test_short_pulse();
    test_fall_glitch();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
